// File: rtl/uart_pkg.sv
// UART shared definitions: TX state encoding,
// 8N1 frame constants and baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;
    localparam int DATA_BITS  = 8;

    function automatic int clks_per_bit(
        input int clk_freq,
        input int baud_rate
    );
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: ticks in the last cycle of each bit,
// synchronous clear holds it at zero between frames.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter draining a registered-read sync FIFO,
// one read strobe per byte, LSB first.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    tx_state_e             r_state;
    tx_state_e             w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [IW-1:0]         r_bit_idx;
    logic                  r_tx;
    logic                  w_tick;
    logic                  w_clear;
    logic                  w_go;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_clear),
        .o_tick (w_tick)
    );

    assign w_go = tx_en && !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter runs only while a bit is on the line
    always_comb begin
        w_next    = r_state;
        fifo_r_en = 1'b0;
        tx_done   = 1'b0;
        w_clear   = 1'b1;
        unique case (r_state)
            IDLE: begin
                if (w_go) w_next = FETCH;
            end
            FETCH: begin
                fifo_r_en = 1'b1;
                w_next    = LOAD;
            end
            LOAD: begin
                w_next = START;
            end
            START: begin
                w_clear = 1'b0;
                if (w_tick) w_next = DATA;
            end
            DATA: begin
                w_clear = 1'b0;
                if (w_tick && r_bit_idx == LAST_BIT) w_next = STOP;
            end
            STOP: begin
                w_clear = 1'b0;
                if (w_tick) begin
                    tx_done = 1'b1;
                    w_next  = w_go ? FETCH : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            unique case (r_state)
                LOAD: begin
                    r_shift   <= fifo_data;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b0;
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx behind a 4-deep registered-read FIFO;
// a line monitor decodes frames into a queue matched to pushes.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CLKS  = 10;
    localparam int FRAME = 10 * CLKS;

    typedef struct {
        logic [7:0] data;
        bit         start_ok;
        bit         stop_ok;
        int         done_cnt;
        bit         done_last;
        int         fall;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_r_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic       wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] f_mem [4];
    logic [7:0] f_rdata = 8'h00;
    int         f_rp = 0;
    int         f_wp = 0;
    int         f_cnt = 0;

    int cyc = 0;
    int ren_cnt = 0;
    int bad_ren = 0;
    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    frame_t     rx_q[$];

    fifo_uart_tx #(
        .CLK_FREQ  (100),
        .BAUD_RATE (10),
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_r_en (fifo_r_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (f_cnt == 0);
    assign fifo_data  = f_rdata;

    always @(posedge clk) begin
        if (fifo_r_en && f_cnt != 0) begin
            f_rdata <= f_mem[f_rp];
            f_rp    <= (f_rp + 1) % 4;
        end
        if (wr && f_cnt < 4) begin
            f_mem[f_wp] <= wdata;
            f_wp        <= (f_wp + 1) % 4;
        end
        f_cnt <= f_cnt + ((wr && f_cnt < 4) ? 1 : 0)
                       - ((fifo_r_en && f_cnt != 0) ? 1 : 0);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_r_en) ren_cnt <= ren_cnt + 1;
        if (fifo_r_en && fifo_empty) bad_ren <= bad_ren + 1;
    end

    // Frame decoder: k counts negedges from the first low sample
    always begin : mon
        frame_t f;
        @(negedge clk);
        if (rst === 1'b1 && tx === 1'b0) begin
            f.fall      = cyc;
            f.data      = 8'h00;
            f.start_ok  = 1'b0;
            f.stop_ok   = 1'b0;
            f.done_cnt  = (tx_done === 1'b1) ? 1 : 0;
            f.done_last = 1'b0;
            for (int k = 2; k <= FRAME; k++) begin
                @(negedge clk);
                if (tx_done === 1'b1) begin
                    f.done_cnt++;
                    if (k == FRAME) f.done_last = 1'b1;
                end
                if (k == 5) f.start_ok = (tx === 1'b0);
                if (k >= 15 && k <= 85 && (k - 15) % 10 == 0)
                    f.data[(k - 15) / 10] = tx;
                if (k == 95) f.stop_ok = (tx === 1'b1);
            end
            rx_q.push_back(f);
        end
    end

    task automatic push(input logic [7:0] b, input bit track, output int pc);
        @(negedge clk);
        wr    = 1'b1;
        wdata = b;
        if (track) exp_q.push_back(b);
        @(negedge clk);
        wr = 1'b0;
        pc = cyc;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_line: tx=%b busy=%b, want tx=1 busy=0", tx, busy);
        end
        checks++;
        if (fifo_r_en !== 1'b0 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: r_en=%b done=%b, want 0 0",
                     fifo_r_en, tx_done);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int pc, r0;
        bit ok;
        frame_t f;
        logic [7:0] e;
        tx_en = 1'b1;
        r0 = ren_cnt;
        push(8'hA5, 1'b1, pc);
        wait_rx(1, FRAME + 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout: frames=%0d, want 1", rx_q.size());
        end else begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (f.data !== e || !f.start_ok || !f.stop_ok) begin
                failures++;
                $display("FAIL single_frame: data=%h st=%b sp=%b, want %h 1 1",
                         f.data, f.start_ok, f.stop_ok, e);
            end
            checks++;
            if (f.done_cnt != 1 || !f.done_last) begin
                failures++;
                $display("FAIL single_done: pulses=%0d at_end=%b, want 1 1",
                         f.done_cnt, f.done_last);
            end
            checks++;
            if (f.fall != pc + 3) begin
                failures++;
                $display("FAIL single_latency: fall=%0d, want %0d", f.fall, pc + 3);
            end
        end
        checks++;
        if (ren_cnt - r0 != 1) begin
            failures++;
            $display("FAIL single_ren: pulses=%0d, want 1", ren_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int pc, r0, prev;
        bit ok;
        frame_t f;
        logic [7:0] e;
        r0 = ren_cnt;
        prev = -1;
        push(8'h00, 1'b1, pc);
        push(8'hFF, 1'b1, pc);
        push(8'h3C, 1'b1, pc);
        wait_rx(3, 3 * FRAME + 60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout: frames=%0d, want 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                f = rx_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (f.data !== e || !f.start_ok || !f.stop_ok ||
                    f.done_cnt != 1 || !f.done_last) begin
                    failures++;
                    $display("FAIL b2b_frame%0d: data=%h st=%b sp=%b done=%0d, want %h 1 1 1",
                             i, f.data, f.start_ok, f.stop_ok, f.done_cnt, e);
                end
                if (prev >= 0) begin
                    checks++;
                    if (f.fall - prev != FRAME + 2) begin
                        failures++;
                        $display("FAIL b2b_gap%0d: spacing=%0d, want %0d",
                                 i, f.fall - prev, FRAME + 2);
                    end
                end
                prev = f.fall;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ren_cnt - r0 != 3 || f_cnt != 0) begin
            failures++;
            $display("FAIL b2b_ren: pulses=%0d fifo=%0d, want 3 0", ren_cnt - r0, f_cnt);
        end
    endtask

    task automatic test_idle_empty();
        int viol;
        viol = 0;
        tx_en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (fifo_r_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL idle_empty: bad_cycles=%0d, want 0", viol);
        end
    endtask

    task automatic test_tx_en_gate();
        int pc, r0;
        bit ok;
        frame_t f;
        logic [7:0] e;
        r0 = ren_cnt;
        tx_en = 1'b1;
        push(8'h5A, 1'b1, pc);
        push(8'hC3, 1'b1, pc);
        repeat (20) @(negedge clk);
        tx_en = 1'b0;
        wait_rx(1, FRAME + 40, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || f_cnt != 1 || ren_cnt - r0 != 1) begin
            failures++;
            $display("FAIL gate_hold: busy=%b fifo=%0d pulses=%0d, want 0 1 1",
                     busy, f_cnt, ren_cnt - r0);
        end
        tx_en = 1'b1;
        wait_rx(2, FRAME + 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL gate_timeout: frames=%0d, want 2", rx_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                f = rx_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (f.data !== e || !f.start_ok || !f.stop_ok || f.done_cnt != 1) begin
                    failures++;
                    $display("FAIL gate_frame%0d: data=%h st=%b sp=%b done=%0d, want %h 1 1 1",
                             i, f.data, f.start_ok, f.stop_ok, f.done_cnt, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pc;
        bit ok, seen;
        frame_t f;
        logic [7:0] e;
        seen = 1'b0;
        tx_en = 1'b1;
        push(8'h81, 1'b0, pc);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rstmid_start: tx=%b, want a start bit", tx);
        end
        repeat (35) @(negedge clk);
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: tx=%b busy=%b, want 0 1", tx, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: tx=%b busy=%b, want 1 0", tx, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        rx_q.delete();
        push(8'h42, 1'b1, pc);
        wait_rx(1, FRAME + 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_timeout: frames=%0d, want 1", rx_q.size());
        end else begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (f.data !== e || !f.start_ok || !f.stop_ok || f.fall != pc + 3) begin
                failures++;
                $display("FAIL rstmid_frame: data=%h st=%b sp=%b fall=%0d, want %h 1 1 %0d",
                         f.data, f.start_ok, f.stop_ok, f.fall, e, pc + 3);
            end
        end
    endtask

    task automatic test_fill();
        int pc, r0;
        bit ok;
        frame_t f;
        logic [7:0] e;
        logic [7:0] bytes [4];
        bytes = '{8'h11, 8'hE7, 8'h80, 8'h01};
        tx_en = 1'b0;
        r0 = ren_cnt;
        for (int i = 0; i < 4; i++) push(bytes[i], 1'b1, pc);
        repeat (3) @(negedge clk);
        checks++;
        if (f_cnt != 4 || busy !== 1'b0 || ren_cnt != r0) begin
            failures++;
            $display("FAIL fill_hold: fifo=%0d busy=%b pulses=%0d, want 4 0 0",
                     f_cnt, busy, ren_cnt - r0);
        end
        tx_en = 1'b1;
        wait_rx(4, 4 * FRAME + 60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fill_timeout: frames=%0d, want 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                f = rx_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (f.data !== e || !f.start_ok || !f.stop_ok || f.done_cnt != 1) begin
                    failures++;
                    $display("FAIL fill_frame%0d: data=%h st=%b sp=%b done=%0d, want %h 1 1 1",
                             i, f.data, f.start_ok, f.stop_ok, f.done_cnt, e);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ren_cnt - r0 != 4 || f_cnt != 0 || bad_ren != 0) begin
            failures++;
            $display("FAIL fill_ren: pulses=%0d fifo=%0d empty_reads=%0d, want 4 0 0",
                     ren_cnt - r0, f_cnt, bad_ren);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_idle_empty();
        test_tx_en_gate();
        test_reset_mid();
        test_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
